// File: rtl/encoder_homing_controller.sv
// Homing sequencer: seek limit, back off, find index, clear the encoder counter. All outputs are registered.
// Reacts to start, abort and synced inputs on the next clock. There is no backpressure, and abort overrides any transition.
module encoder_homing_controller #(
    parameter int COUNT_WIDTH    = 32,
    parameter int BACKOFF_COUNTS = 64,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   limit_sw,
    input  logic                   index,
    input  logic [COUNT_WIDTH-1:0] pulse_count,
    output logic                   motor_en,
    output logic                   motor_dir,
    output logic                   cnt_clear,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [COUNT_WIDTH-1:0] home_pos
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEEK_LIMIT, S_BACKOFF, S_SEEK_INDEX, S_ZERO, S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] limit_sync_q, limit_sync_d;
    logic [SYNC_STAGES-1:0] index_sync_q, index_sync_d;
    logic                   index_prev_q, index_prev_d;
    logic [COUNT_WIDTH-1:0] ref_q, ref_d;
    logic                   motor_en_q, motor_en_d;
    logic                   motor_dir_q, motor_dir_d;
    logic                   cnt_clear_q, cnt_clear_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [COUNT_WIDTH-1:0] home_pos_q, home_pos_d;

    logic                   limit_s, index_s, index_edge, timeout;
    logic [COUNT_WIDTH-1:0] travel;

    assign limit_s    = limit_sync_q[SYNC_STAGES-1];
    assign index_s    = index_sync_q[SYNC_STAGES-1];
    assign index_edge = index_s & ~index_prev_q;
    assign timeout    = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    // Modular distance: stays correct when the counter wraps through zero.
    assign travel     = pulse_count - ref_q;

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        motor_en_d   = motor_en_q;
        motor_dir_d  = motor_dir_q;
        busy_d       = busy_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        home_pos_d   = home_pos_q;
        cnt_clear_d  = 1'b0;
        done_d       = 1'b0;
        limit_sync_d = {limit_sync_q[SYNC_STAGES-2:0], limit_sw};
        index_sync_d = {index_sync_q[SYNC_STAGES-2:0], index};
        index_prev_d = index_s;

        if (abort && (state_q inside {S_SEEK_LIMIT, S_BACKOFF, S_SEEK_INDEX, S_ZERO})) begin
            state_d     = S_IDLE;
            motor_en_d  = 1'b0;
            motor_dir_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FAULT: begin
                    if (start && !abort) begin
                        state_d     = S_SEEK_LIMIT;
                        motor_en_d  = 1'b1;
                        motor_dir_d = 1'b0;
                        busy_d      = 1'b1;
                        error_d     = 1'b0;
                        err_code_d  = 2'b00;
                    end
                end
                S_SEEK_LIMIT: begin
                    if (limit_s) begin
                        state_d     = S_BACKOFF;
                        ref_d       = pulse_count;
                        motor_dir_d = 1'b1;
                    end else if (timeout) begin
                        state_d    = S_FAULT;
                        err_code_d = 2'b01;
                    end
                end
                S_BACKOFF: begin
                    if (travel >= COUNT_WIDTH'(BACKOFF_COUNTS) && !limit_s) begin
                        state_d = S_SEEK_INDEX;
                    end else if (timeout) begin
                        state_d    = S_FAULT;
                        err_code_d = 2'b10;
                    end
                end
                S_SEEK_INDEX: begin
                    // Touching the limit again means the index was missed.
                    if (limit_s || timeout) begin
                        state_d    = S_FAULT;
                        err_code_d = 2'b11;
                    end else if (index_edge) begin
                        state_d     = S_ZERO;
                        home_pos_d  = pulse_count;
                        motor_en_d  = 1'b0;
                        cnt_clear_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
                S_ZERO: begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    motor_dir_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase

            if (state_d == S_FAULT && state_q != S_FAULT) begin
                motor_en_d  = 1'b0;
                motor_dir_d = 1'b0;
                busy_d      = 1'b0;
                error_d     = 1'b1;
            end
        end

        if (state_d != state_q || state_q inside {S_IDLE, S_ZERO, S_FAULT}) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            limit_sync_q <= '0;
            index_sync_q <= '0;
            index_prev_q <= 1'b0;
            ref_q        <= '0;
            motor_en_q   <= 1'b0;
            motor_dir_q  <= 1'b0;
            cnt_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
            home_pos_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            limit_sync_q <= limit_sync_d;
            index_sync_q <= index_sync_d;
            index_prev_q <= index_prev_d;
            ref_q        <= ref_d;
            motor_en_q   <= motor_en_d;
            motor_dir_q  <= motor_dir_d;
            cnt_clear_q  <= cnt_clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            home_pos_q   <= home_pos_d;
        end
    end

    assign motor_en  = motor_en_q;
    assign motor_dir = motor_dir_q;
    assign cnt_clear = cnt_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign home_pos  = home_pos_q;
endmodule
